jtag_ahb_dr: RTL and testbench
==============================

Name: jtag_ahb_dr

Overview:
- JTAG-side AHB access data register in the TCK domain, directly upstream of the AHB register/bridge stage.
- Shifts a 39-bit command frame in from TDI and decodes it on Update-DR.
- Holds the target address, write data and status, and issues a single-outstanding req/ack transaction to the downstream consumer.
- On Capture-DR it loads status and read data so the host can scan them out through TDO.

Parameters:
- ADDR_WIDTH, 32, width of the target address register.
- DATA_WIDTH, 32, width of the write-data, read-data and payload fields.
- DR_WIDTH, DATA_WIDTH+7, scan frame length (39 by default). Must not be overridden independently of DATA_WIDTH.

Ports:
- TCK  in  1  test clock. All logic is on posedge TCK.
- TRST  in  1  reset, synchronous, active-high. Polarity and synchronicity are fixed for this block.
- ahb_select  in  1  AHB DR selected by the instruction register.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR.
- update_dr  in  1  TAP in Update-DR.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, equal to shreg[0].
- req  out  1  transaction request to downstream.
- req_write  out  1  1 = write, 0 = read.
- req_size  out  2  0 = byte, 1 = half, 2 = word.
- req_addr  out  ADDR_WIDTH  target address.
- req_wdata  out  DATA_WIDTH  write data.
- ack  in  1  downstream completion, single-cycle pulse.
- ack_err  in  1  error flag, valid with ack.
- ack_rdata  in  DATA_WIDTH  read data, valid with ack.

Behaviour:
- Frame layout:
  - [38:36] cmd.
  - [35] autoinc.
  - [34:33] size.
  - [32] reserved, ignored.
  - [31:0] payload.
- cmd encoding: 000 NOP, 001 SET_ADDR, 010 WRITE, 011 READ, 100 CLR_STATUS. 101–111 are treated as NOP.
- Reset (TRST=1 at a posedge): shreg, addr_q, wdata_q, rdata_q, size_q, autoinc_q, err, overrun and req_write are 0, state = IDLE, req = 0. TDO is 0.
- All TAP actions are qualified by ahb_select. Priority when several are asserted: update_dr > capture_dr > shift_dr.
- Shift: shreg <= {TDI, shreg[DR_WIDTH-1:1]}.
- Capture: shreg <= {busy, err, overrun, 4'b0, rdata_q}, where busy = (state == PEND).
- Update in IDLE:
  - SET_ADDR: addr_q <= payload.
  - CLR_STATUS: err <= 0 and overrun <= 0.
  - WRITE: wdata_q <= payload, latch size/autoinc, req_write <= 1, state <= PEND.
  - READ: latch size/autoinc, req_write <= 0, state <= PEND.
  - NOP: no effect.
- Update in PEND: the frame is discarded and overrun <= 1. State is sampled before any same-cycle ack.
- size = 3 is treated as 2 (word).
- FSM has two states, IDLE and PEND.
  - req = (state == PEND), so req rises the cycle after the Update-DR cycle.
  - req_* outputs are driven from the latched registers and are stable while req is high.
- ack in PEND:
  - rdata_q <= ack_rdata on a read.
  - err <= err | ack_err.
  - If autoinc && !ack_err: addr_q <= addr_q + (1 << size_q), wrapping modulo 2^ADDR_WIDTH.
  - state <= IDLE, so req falls the next cycle.
- ack in IDLE is ignored.
- Simultaneous ack and update while in PEND: the ack completes normally, the update sets overrun, and no new request is issued.
- TRST asserted during PEND aborts the transaction. req drops on the next cycle and no ack is awaited.

Decomposition:
- Package jtag_ahb_pkg holds:
  - the cmd_t enum (NOP, SET_ADDR, WRITE, READ, CLR_STATUS);
  - the size_t encoding;
  - the state_t enum (IDLE, PEND);
  - frame bit-position constants (CMD_MSB/LSB, AUTOINC_BIT, SIZE_MSB/LSB, PAYLOAD_MSB);
  - status-field positions.
- Sub-module jtag_shift_reg: parameterised DR_WIDTH shift register with capture-load input and TDO output. It is reusable by other DRs.
- FSM, decode and address logic stay in jtag_ahb_dr.

Test Plan:
- Reset, then Capture-DR and 39 shift cycles → TDO stream is all 0, req = 0.
- SET_ADDR 0x2000_0000, then WRITE payload 0xDEADBEEF with size = 2 → req rises 1 cycle after update with req_write = 1, addr 0x20000000, wdata 0xDEADBEEF. ack → req low the next cycle.
- READ with autoinc = 1 and size = 2, ack_rdata = 0x12345678 → capture/shift shows busy = 0, err = 0, rdata 0x12345678. A following READ issues addr 0x20000004.
- SET_ADDR 0xFFFFFFFC, READ autoinc word, ack → addr_q wraps to 0x00000000. An ack_err = 1 case leaves addr unchanged and the captured err = 1.
- WRITE issued, then a second update while PEND (including one in the same cycle as ack) → the second frame is dropped and overrun = 1. CLR_STATUS then clears err and overrun.
- TRST during PEND → req = 0 the next cycle, state IDLE, and all registers read back 0 on capture.

Source files
------------

// File: rtl/jtag_ahb_pkg.sv
// Shared types and frame layout for the JTAG AHB access data register.
// Bit positions are given for the default 32-bit payload; users rebase them on DATA_WIDTH.
package jtag_ahb_pkg;

    typedef enum logic [2:0] {
        CMD_NOP        = 3'b000,
        CMD_SET_ADDR   = 3'b001,
        CMD_WRITE      = 3'b010,
        CMD_READ       = 3'b011,
        CMD_CLR_STATUS = 3'b100
    } cmd_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam int CMD_MSB     = 38;
    localparam int CMD_LSB     = 36;
    localparam int AUTOINC_BIT = 35;
    localparam int SIZE_MSB    = 34;
    localparam int SIZE_LSB    = 33;
    localparam int PAYLOAD_MSB = 31;

    localparam int STAT_BUSY_BIT = 38;
    localparam int STAT_ERR_BIT  = 37;
    localparam int STAT_OVR_BIT  = 36;

    // The unused size code 3 behaves as a word access.
    function automatic size_t norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SIZE_WORD : size_t'(raw);
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG data register: parallel capture load, LSB-first serial shift, TDO = bit 0.
// Capture takes priority over shift; the caller resolves any higher-priority TAP action.
module jtag_shift_reg #(
    parameter int DR_WIDTH = 39
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                capture,
    input  logic                shift,
    input  logic                tdi,
    input  logic [DR_WIDTH-1:0] capture_data,
    output logic [DR_WIDTH-1:0] data,
    output logic                tdo
);

    logic [DR_WIDTH-1:0] shreg_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            shreg_reg <= '0;
        end else if (capture) begin
            shreg_reg <= capture_data;
        end else if (shift) begin
            shreg_reg <= {tdi, shreg_reg[DR_WIDTH-1:1]};
        end
    end

    assign data = shreg_reg;
    assign tdo  = shreg_reg[0];

endmodule

// File: rtl/jtag_ahb_dr.sv
// JTAG-side AHB access DR: decodes scanned command frames on Update-DR and runs a
// single-outstanding req/ack transaction; Capture-DR presents status and read data.
module jtag_ahb_dr
    import jtag_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DR_WIDTH   = DATA_WIDTH + 7
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  ahb_select,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  req,
    output logic                  req_write,
    output logic [1:0]            req_size,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  ack,
    input  logic                  ack_err,
    input  logic [DATA_WIDTH-1:0] ack_rdata
);

    // Rebase the package bit positions onto the configured payload width.
    localparam int OFS = DATA_WIDTH - (PAYLOAD_MSB + 1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            size_reg;
    logic                  autoinc_reg;
    logic                  err_reg;
    logic                  overrun_reg;
    logic                  write_reg;

    logic                  upd, cap, shf;
    logic [DR_WIDTH-1:0]   dr;
    logic [DR_WIDTH-1:0]   status;
    cmd_t                  cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic                  frame_autoinc;
    logic [1:0]            frame_size;
    logic                  reserved_unused;
    logic                  busy;

    assign upd = ahb_select & update_dr;
    assign cap = ahb_select & capture_dr & ~update_dr;
    assign shf = ahb_select & shift_dr & ~update_dr & ~capture_dr;

    assign busy   = (state_reg == ST_PEND);
    assign status = {busy, err_reg, overrun_reg, 4'b0000, rdata_reg};

    jtag_shift_reg #(
        .DR_WIDTH (DR_WIDTH)
    ) u_shift (
        .clk          (TCK),
        .srst         (TRST),
        .capture      (cap),
        .shift        (shf),
        .tdi          (TDI),
        .capture_data (status),
        .data         (dr),
        .tdo          (TDO)
    );

    assign cmd             = cmd_t'(dr[CMD_MSB+OFS:CMD_LSB+OFS]);
    assign frame_autoinc   = dr[AUTOINC_BIT+OFS];
    assign frame_size      = norm_size(dr[SIZE_MSB+OFS:SIZE_LSB+OFS]);
    assign payload         = dr[DATA_WIDTH-1:0];
    assign reserved_unused = dr[DATA_WIDTH];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (upd && (cmd == CMD_WRITE || cmd == CMD_READ)) state_next = ST_PEND;
            ST_PEND: if (ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            size_reg    <= '0;
            autoinc_reg <= 1'b0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
            write_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (upd && state_reg == ST_IDLE) begin
                case (cmd)
                    CMD_SET_ADDR:   addr_reg <= ADDR_WIDTH'(payload);
                    CMD_CLR_STATUS: begin
                        err_reg     <= 1'b0;
                        overrun_reg <= 1'b0;
                    end
                    CMD_WRITE: begin
                        wdata_reg   <= payload;
                        size_reg    <= frame_size;
                        autoinc_reg <= frame_autoinc;
                        write_reg   <= 1'b1;
                    end
                    CMD_READ: begin
                        size_reg    <= frame_size;
                        autoinc_reg <= frame_autoinc;
                        write_reg   <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // A frame arriving while busy is dropped, even if ack completes this cycle.
            if (upd && state_reg == ST_PEND) overrun_reg <= 1'b1;
            if (ack && state_reg == ST_PEND) begin
                if (!write_reg) rdata_reg <= ack_rdata;
                err_reg <= err_reg | ack_err;
                if (autoinc_reg && !ack_err) addr_reg <= addr_reg + (ADDR_WIDTH'(1) << size_reg);
            end
        end
    end

    assign req       = busy;
    assign req_write = write_reg;
    assign req_size  = size_reg;
    assign req_addr  = addr_reg;
    assign req_wdata = wdata_reg;

endmodule

// File: tb/tb_jtag_ahb_dr.sv
// Scoreboard bench for jtag_ahb_dr: expected requests and captured status words are queued
// when frames are scanned and checked when the DUT raises req or the capture is shifted out.
module tb_jtag_ahb_dr;

    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        ahb_select = 1'b0;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        TDI = 1'b0;
    logic        TDO;
    logic        req;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ack = 1'b0;
    logic        ack_err = 1'b0;
    logic [31:0] ack_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    req_t        req_q[$];
    logic [38:0] cap_q[$];

    // Reference model state
    logic        m_busy, m_err, m_ovr, m_write, m_autoinc;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    jtag_ahb_dr dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .ahb_select (ahb_select),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .TDI        (TDI),
        .TDO        (TDO),
        .req        (req),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .ack_err    (ack_err),
        .ack_rdata  (ack_rdata)
    );

    always #5 TCK = ~TCK;

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    function automatic logic [38:0] frame(input logic [2:0] c, input logic ai,
                                          input logic [1:0] sz, input logic [31:0] p);
        return {c, ai, sz, 1'b0, p};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_ovr = 0; m_write = 0; m_autoinc = 0;
        m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    endtask

    task automatic model_ack(input logic e, input logic [31:0] rd);
        if (!m_write) m_rdata = rd;
        m_err = m_err | e;
        if (m_autoinc && !e) m_addr = m_addr + (32'd1 << m_size);
        m_busy = 0;
    endtask

    task automatic model_update(input logic [38:0] din, input bit with_ack, input logic [31:0] rd);
        logic       pre_busy;
        logic [2:0] c;
        pre_busy = m_busy;
        c = din[38:36];
        if (with_ack && pre_busy) model_ack(1'b0, rd);
        if (pre_busy) begin
            m_ovr = 1;
        end else begin
            case (c)
                3'b001: m_addr = din[31:0];
                3'b100: begin m_err = 0; m_ovr = 0; end
                3'b010, 3'b011: begin
                    m_write   = (c == 3'b010);
                    if (m_write) m_wdata = din[31:0];
                    m_size    = (din[34:33] == 2'd3) ? 2'd2 : din[34:33];
                    m_autoinc = din[35];
                    m_busy    = 1;
                    req_q.push_back('{m_write, m_size, m_addr, m_wdata});
                end
                default: ;
            endcase
        end
    endtask

    // Capture, shift the full frame in while collecting TDO, optionally update.
    task automatic scan(input logic [38:0] din, input bit do_upd, input bit with_ack,
                        input logic [31:0] ack_rd, input string name);
        logic [38:0] dout;
        logic [38:0] exp;
        ahb_select = 1;
        capture_dr = 1;
        cap_q.push_back({m_busy, m_err, m_ovr, 4'b0000, m_rdata});
        tick();
        capture_dr = 0;
        shift_dr = 1;
        for (int i = 0; i < 39; i++) begin
            dout[i] = TDO;
            TDI = din[i];
            tick();
        end
        shift_dr = 0;
        exp = cap_q.pop_front();
        vectors++;
        if (dout !== exp) begin
            miscompares++;
            $display("FAIL capture_%s: got %h expected %h", name, dout, exp);
        end else begin
            $display("capture_%s: status %h", name, dout);
        end
        if (do_upd) begin
            update_dr = 1;
            if (with_ack) begin
                ack = 1; ack_err = 0; ack_rdata = ack_rd;
            end
            model_update(din, with_ack, ack_rd);
            tick();
            update_dr = 0;
            ack = 0;
        end
        ahb_select = 0;
    endtask

    task automatic check_req(input string name);
        req_t e;
        vectors++;
        if (req_q.size() == 0) begin
            miscompares++;
            $display("FAIL req_%s: req=%b with no request expected (required 0)", name, req);
            return;
        end
        e = req_q.pop_front();
        if (req !== 1'b1 || req_write !== e.w || req_size !== e.sz ||
            req_addr !== e.a || req_wdata !== e.d) begin
            miscompares++;
            $display("FAIL req_%s: got req=%b w=%b sz=%0d a=%h d=%h expected req=1 w=%b sz=%0d a=%h d=%h",
                     name, req, req_write, req_size, req_addr, req_wdata, e.w, e.sz, e.a, e.d);
        end else begin
            $display("req_%s: w=%b sz=%0d a=%h d=%h", name, req_write, req_size, req_addr, req_wdata);
        end
    endtask

    task automatic do_ack(input logic e, input logic [31:0] rd, input string name);
        ack = 1; ack_err = e; ack_rdata = rd;
        if (m_busy) model_ack(e, rd);
        tick();
        ack = 0; ack_err = 0;
        vectors++;
        if (req !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_%s: req=%b after ack, expected 0", name, req);
        end else begin
            $display("ack_%s: err=%b rdata=%h req dropped", name, e, rd);
        end
    endtask

    task automatic test_reset();
        TRST = 1;
        tick();
        tick();
        TRST = 0;
        model_reset();
        vectors++;
        if (req !== 1'b0 || TDO !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b TDO=%b expected 0 0", req, TDO);
        end else $display("reset_outputs: req=0 TDO=0");
        scan(39'd0, 1'b0, 1'b0, 32'd0, "reset");
    endtask

    task automatic test_write();
        scan(frame(3'b001, 0, 2'd0, 32'h2000_0000), 1, 0, 0, "set_addr");
        vectors++;
        if (req !== 1'b0) begin
            miscompares++;
            $display("FAIL set_addr_noreq: req=%b expected 0", req);
        end
        scan(frame(3'b010, 0, 2'd2, 32'hDEAD_BEEF), 1, 0, 0, "write");
        check_req("write");
        do_ack(0, 32'h0, "write");
    endtask

    task automatic test_read_autoinc();
        scan(frame(3'b011, 1, 2'd2, 32'h0), 1, 0, 0, "read_ai");
        check_req("read_ai");
        do_ack(0, 32'h1234_5678, "read_ai");
        scan(frame(3'b011, 0, 2'd2, 32'h0), 1, 0, 0, "read_next");
        check_req("read_next");
        do_ack(0, 32'hCAFE_F00D, "read_next");
    endtask

    task automatic test_wrap();
        scan(frame(3'b001, 0, 2'd0, 32'hFFFF_FFFC), 1, 0, 0, "set_top");
        scan(frame(3'b011, 1, 2'd2, 32'h0), 1, 0, 0, "read_top");
        check_req("read_top");
        do_ack(0, 32'hA5A5_0001, "read_top");
        scan(frame(3'b011, 1, 2'd2, 32'h0), 1, 0, 0, "read_wrapped");
        check_req("read_wrapped");
        do_ack(1, 32'hA5A5_0002, "read_err");
        scan(frame(3'b001, 0, 2'd0, 32'h0000_0010), 1, 0, 0, "set_10");
        scan(frame(3'b011, 1, 2'd3, 32'h0), 1, 0, 0, "read_sz3");
        check_req("read_sz3");
        do_ack(0, 32'h0000_0033, "read_sz3");
        scan(frame(3'b011, 1, 2'd0, 32'h0), 1, 0, 0, "read_byte");
        check_req("read_byte");
        do_ack(0, 32'h0000_0044, "read_byte");
        scan(frame(3'b011, 0, 2'd1, 32'h0), 1, 0, 0, "read_after_byte");
        check_req("read_after_byte");
        do_ack(0, 32'h0000_0055, "read_after_byte");
    endtask

    task automatic test_overrun();
        scan(frame(3'b010, 0, 2'd2, 32'h1111_2222), 1, 0, 0, "write_pend");
        check_req("write_pend");
        scan(frame(3'b010, 0, 2'd2, 32'h3333_4444), 1, 0, 0, "write_drop");
        vectors++;
        if (req !== 1'b1 || req_wdata !== 32'h1111_2222 || req_q.size() != 0) begin
            miscompares++;
            $display("FAIL overrun_hold: req=%b wdata=%h expected req=1 wdata=11112222", req, req_wdata);
        end else $display("overrun_hold: request unchanged");
        scan(frame(3'b011, 0, 2'd2, 32'h0), 1, 1, 32'h7777_7777, "update_with_ack");
        vectors++;
        if (req !== 1'b0 || req_q.size() != 0) begin
            miscompares++;
            $display("FAIL ack_update: req=%b expected 0 (no new request)", req);
        end else $display("ack_update: completed, no new request");
        do_ack(0, 32'h0BAD_0BAD, "idle_ignored");
        scan(frame(3'b100, 0, 2'd0, 32'h0), 1, 0, 0, "clr_status");
        scan(39'd0, 1'b0, 1'b0, 32'd0, "after_clr");
    endtask

    task automatic test_trst_pend();
        scan(frame(3'b010, 1, 2'd2, 32'h55AA_55AA), 1, 0, 0, "write_abort");
        check_req("write_abort");
        TRST = 1;
        tick();
        TRST = 0;
        model_reset();
        vectors++;
        if (req !== 1'b0 || req_addr !== 32'h0 || req_wdata !== 32'h0 ||
            req_write !== 1'b0 || req_size !== 2'd0 || TDO !== 1'b0) begin
            miscompares++;
            $display("FAIL trst_abort: req=%b a=%h d=%h w=%b sz=%0d TDO=%b expected all 0",
                     req, req_addr, req_wdata, req_write, req_size, TDO);
        end else $display("trst_abort: req dropped, registers cleared");
        scan(39'd0, 1'b0, 1'b0, 32'd0, "after_trst");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write();
        test_read_autoinc();
        test_wrap();
        test_overrun();
        test_trst_pend();
        vectors++;
        if (req_q.size() != 0 || cap_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d requests %0d captures left, expected 0 0",
                     req_q.size(), cap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
